banked_mem_arbiter: RTL and testbench
=====================================

// Module: banked_mem_arbiter
// PURPOSE
//   Multi-bank shared memory with one round-robin arbiter per bank. Sits between
//   all cores and shared memory.
//   Cores that address different banks are served in the same cycle; cores that
//   collide on one bank are serialised fairly.
//   Each core gets a ready pulse, plus read data for reads, one cycle after its grant.
// PARAMETERS
//   NUM_CORES   16  number of requesting cores (>=2)
//   NUM_BANKS   4   number of banks, power of two (>=2)
//   REG_SIZE    8   data word width in bits
//   ADDR_SIZE   8   per-core address width; upper log2(NUM_BANKS) bits select the
//                   bank, lower bits select the word; depth per bank = 2**(ADDR_SIZE-BB)
// PORTS
//   clk      in   1                    clock, all state on rising edge
//   reset    in   1                    asynchronous, active-high
//   enable   in   2*NUM_CORES          per core {wr,rd}; core c at [2c+1:2c]
//   addr     in   ADDR_SIZE*NUM_CORES  core c at [(c+1)*ADDR_SIZE-1 : c*ADDR_SIZE]
//   wr_data  in   REG_SIZE*NUM_CORES   core c at [(c+1)*REG_SIZE-1 : c*REG_SIZE]
//   rd_data  out  REG_SIZE*NUM_CORES   read data per core, same packing as wr_data
//   ready    out  NUM_CORES            one-cycle completion pulse per core
//   stall_cnt out 16                   present only with ARB_STALL_CNT_EN
// BEHAVIOUR
//   - Reset: ready=0, rd_data=0, in-flight mask=0, every bank pointer=NUM_CORES-1
//     (so core 0 wins first), stall_cnt=0.
//   - Memory contents are not reset. Reading an unwritten word returns an undefined value.
//   - Request encoding: 2'b01 is a read. 2'b10 and 2'b11 are writes (write wins);
//     2'b11 returns rd_data=0. 2'b00 is idle.
//   - Eligibility: core c is eligible when enable[c]!=0 and its in-flight bit is 0.
//   - Arbitration, per bank b, combinational in cycle t:
//     - Scan the eligible cores whose bank field equals b.
//     - Scan order is ptr[b]+1, ptr[b]+2, ... modulo NUM_CORES.
//     - The first match is granted, and at most one grant is made per bank.
//   - At the clk edge ending cycle t:
//     - Granted write: mem[b][word] <= wr_data.
//     - Granted read: data is captured into that core's response register.
//     - ptr[b] <= granted core id. Banks with no grant keep their pointer.
//     - Granted cores get in-flight=1. All other in-flight bits clear to 0.
//   - Cycle t+1:
//     - ready[c]=1 for exactly this cycle.
//     - rd_data[c] holds the read word, or 0 for a write. It is 0 whenever ready[c]=0.
//   - Latency: 1 cycle from grant to ready. Because of the in-flight mask, a core can
//     complete at most one access every 2 cycles.
//   - Handshake: the core holds enable, addr and wr_data stable until it sees ready.
//     enable still asserted in the cycle after ready counts as a new request.
//   - Read-after-write to the same word in consecutive grants returns the new data.
//   - Parallelism: up to NUM_BANKS grants per cycle. A core never gets more than one
//     grant, since it addresses only one bank.
//   - Denied cores wait with no ready. The pointer rule bounds the wait to NUM_CORES-1
//     grants of that bank.
//   - Reset asserted mid-operation:
//     - Pending ready pulses and rd_data are dropped at once (asynchronous reset).
//     - A write whose edge coincides with reset assertion is not guaranteed to land.
// CONFIGURATION
//   ARB_STALL_CNT_EN defined:
//     - Adds stall_cnt, a 16-bit counter that saturates at 16'hFFFF.
//     - It increments on each cycle in which at least one eligible core is denied.
//     - reset clears it to 0.
//   ARB_STALL_CNT_EN undefined: the port and the counter logic are absent.
//     All other behaviour is identical.
// TESTING
//   1) Reset, then core 0 writes 8'hA5 to addr 8'h03; after ready, reads 8'h03
//      -> ready[0] at grant+1 both times; read returns rd_data[0]=8'hA5.
//   2) Cores 1,2,3 write addrs 8'h00, 8'h40, 8'h80 (banks 0,1,2) in the same cycle
//      -> all three ready pulses occur in the same next cycle; readback matches.
//   3) Cores 0,5,9 all hold reads to bank 0 from reset
//      -> grant order 0,5,9 with readies on cycles 1,2,3. Core 0 re-requesting
//         after its ready is served only after 9.
//   4) Core 4 holds a read continuously -> ready[4] every other cycle; rd_data=0
//      between pulses.
//   5) Assert reset in the cycle a read is granted -> no ready; rd_data=0; ptr=15.
//   6) With ARB_STALL_CNT_EN: scenario 3 -> stall_cnt=2. Force 70000 conflict
//      cycles -> stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/banked_mem_arbiter.sv
// Multi-bank shared memory with a round-robin arbiter per bank; one-cycle grant-to-ready latency.
// Optional ARB_STALL_CNT_EN adds a saturating 16-bit count of cycles with at least one denied core.
module banked_mem_arbiter #(
    parameter int NUM_CORES = 16,
    parameter int NUM_BANKS = 4,
    parameter int REG_SIZE  = 8,
    parameter int ADDR_SIZE = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2*NUM_CORES-1:0]        enable,
    input  logic [ADDR_SIZE*NUM_CORES-1:0] addr,
    input  logic [REG_SIZE*NUM_CORES-1:0] wr_data,
    output logic [REG_SIZE*NUM_CORES-1:0] rd_data,
    output logic [NUM_CORES-1:0]          ready
`ifdef ARB_STALL_CNT_EN
    ,
    output logic [15:0]                   stall_cnt
`endif
);

    localparam int BB    = $clog2(NUM_BANKS);
    localparam int WB    = ADDR_SIZE - BB;
    localparam int DEPTH = 1 << WB;
    localparam int CW    = $clog2(NUM_CORES);

    logic [BB-1:0]       bank_of  [NUM_CORES];
    logic [WB-1:0]       word_of  [NUM_CORES];
    logic [1:0]          req_of   [NUM_CORES];
    logic [REG_SIZE-1:0] wdata_of [NUM_CORES];

    logic [REG_SIZE-1:0] mem [NUM_BANKS][DEPTH];
    logic [CW-1:0]       ptr [NUM_BANKS];
    logic [CW-1:0]       gnt_id [NUM_BANKS];
    logic [NUM_BANKS-1:0] bank_gnt;

    logic [NUM_CORES-1:0] inflight;
    logic [NUM_CORES-1:0] eligible;
    logic [NUM_CORES-1:0] grant;
    logic [REG_SIZE*NUM_CORES-1:0] rd_next;

    always_comb begin
        for (int unsigned c = 0; c < NUM_CORES; c++) begin
            bank_of[c]  = addr[c*ADDR_SIZE + WB +: BB];
            word_of[c]  = addr[c*ADDR_SIZE +: WB];
            req_of[c]   = enable[2*c +: 2];
            wdata_of[c] = wr_data[c*REG_SIZE +: REG_SIZE];
            eligible[c] = (req_of[c] != 2'b00) && !inflight[c];
            rd_next[c*REG_SIZE +: REG_SIZE] =
                (req_of[c] == 2'b01) ? mem[bank_of[c]][word_of[c]] : '0;
        end
    end

    // Scan each bank starting one past the last winner; first eligible hit wins.
    always_comb begin
        int unsigned idx;
        idx      = 0;
        grant    = '0;
        bank_gnt = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            gnt_id[b] = '0;
            for (int unsigned k = 1; k <= NUM_CORES; k++) begin
                idx = (32'(ptr[b]) + k) % NUM_CORES;
                if (!bank_gnt[b] && eligible[idx] && (bank_of[idx] == BB'(b))) begin
                    bank_gnt[b] = 1'b1;
                    gnt_id[b]   = CW'(idx);
                    grant[idx]  = 1'b1;
                end
            end
        end
    end

    // The in-flight mask is exactly the set of cores completing this cycle, so it drives ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= '0;
            rd_data  <= '0;
            for (int unsigned b = 0; b < NUM_BANKS; b++)
                ptr[b] <= CW'(NUM_CORES - 1);
        end else begin
            inflight <= grant;
            for (int unsigned c = 0; c < NUM_CORES; c++)
                rd_data[c*REG_SIZE +: REG_SIZE] <=
                    grant[c] ? rd_next[c*REG_SIZE +: REG_SIZE] : '0;
            for (int unsigned b = 0; b < NUM_BANKS; b++)
                if (bank_gnt[b])
                    ptr[b] <= gnt_id[b];
        end
    end

    assign ready = inflight;

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < NUM_BANKS; b++)
            if (!reset && bank_gnt[b] && req_of[gnt_id[b]][1])
                mem[b][word_of[gnt_id[b]]] <= wdata_of[gnt_id[b]];
    end

`ifdef ARB_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (|(eligible & ~grant) && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_banked_mem_arbiter.sv
// Bench for banked_mem_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic checked against an address-level reference model.
module tb_banked_mem_arbiter;

    localparam int NC = 16;
    localparam int NB = 4;
    localparam int RS = 8;
    localparam int AS = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic [2*NC-1:0]     enable;
    logic [AS*NC-1:0]    addr;
    logic [RS*NC-1:0]    wr_data;
    logic [RS*NC-1:0]    rd_data;
    logic [NC-1:0]       ready;
`ifdef ARB_STALL_CNT_EN
    logic [15:0]         stall_cnt;
`endif

    int unsigned vecs = 0;
    int unsigned miss = 0;

    always #5 clk = ~clk;

    banked_mem_arbiter #(
        .NUM_CORES(NC),
        .NUM_BANKS(NB),
        .REG_SIZE (RS),
        .ADDR_SIZE(AS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .ready    (ready)
`ifdef ARB_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    typedef struct {
        int unsigned core;
        logic [1:0]  en;
        logic [7:0]  ad;
        logic [7:0]  wd;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t tbl[9];

    // reference model state
    logic [1:0]  r_en [NC];
    logic [7:0]  r_ad [NC];
    logic [7:0]  r_wd [NC];
    bit          pend [NC];
    bit          m_inf [NC];
    int unsigned m_ptr [NB];
    logic [7:0]  m_mem [256];
    bit          m_known [256];
    int unsigned m_stall;
    logic [15:0]  exp_ready;
    logic [127:0] exp_rd;
    logic [127:0] known_mask;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int unsigned c, input logic [1:0] e, input logic [7:0] a,
                           input logic [7:0] d);
        enable[2*c +: 2]  = e;
        addr[8*c +: 8]    = a;
        wr_data[8*c +: 8] = d;
    endtask

    task automatic idle_all();
        enable  = '0;
        addr    = '0;
        wr_data = '0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    function automatic logic [127:0] bitm(input int unsigned c);
        logic [127:0] r;
        r    = '0;
        r[c] = 1'b1;
        return r;
    endfunction

    function automatic logic [127:0] lane(input int unsigned c, input logic [7:0] v);
        logic [127:0] r;
        r          = '0;
        r[8*c +: 8] = v;
        return r;
    endfunction

    // Winner per bank = eligible core at the smallest circular distance past the last winner.
    task automatic model_step();
        int unsigned n_elig, n_gnt;
        n_elig     = 0;
        n_gnt      = 0;
        exp_ready  = '0;
        exp_rd     = '0;
        known_mask = '1;
        for (int b = 0; b < NB; b++) begin
            int best, bestd;
            best  = -1;
            bestd = NC;
            for (int c = 0; c < NC; c++) begin
                if (r_en[c] != 2'b00 && !m_inf[c] && int'(r_ad[c][7:6]) == b) begin
                    int d;
                    n_elig++;
                    d = (c + NC - int'(m_ptr[b]) - 1) % NC;
                    if (d < bestd) begin
                        bestd = d;
                        best  = c;
                    end
                end
            end
            if (best >= 0) begin
                n_gnt++;
                exp_ready[best] = 1'b1;
                if (r_en[best] == 2'b01) begin
                    if (m_known[r_ad[best]])
                        exp_rd[8*best +: 8] = m_mem[r_ad[best]];
                    else
                        known_mask[8*best +: 8] = '0;
                end else begin
                    m_mem[r_ad[best]]   = r_wd[best];
                    m_known[r_ad[best]] = 1'b1;
                end
                m_ptr[b] = best;
            end
        end
        for (int c = 0; c < NC; c++)
            m_inf[c] = exp_ready[c];
        if (n_elig > n_gnt && m_stall < 65535)
            m_stall++;
    endtask

    initial begin
        tbl[0] = '{0,  2'b10, 8'h03, 8'hA5, 8'h00};
        tbl[1] = '{0,  2'b01, 8'h03, 8'h00, 8'hA5};
        tbl[2] = '{7,  2'b11, 8'h41, 8'h3C, 8'h00};
        tbl[3] = '{7,  2'b01, 8'h41, 8'h00, 8'h3C};
        tbl[4] = '{15, 2'b10, 8'hFF, 8'hC3, 8'h00};
        tbl[5] = '{2,  2'b01, 8'hFF, 8'h00, 8'hC3};
        tbl[6] = '{3,  2'b01, 8'h03, 8'h00, 8'hA5};
        tbl[7] = '{9,  2'b11, 8'h03, 8'h5A, 8'h00};
        tbl[8] = '{10, 2'b01, 8'h03, 8'h00, 8'h5A};

        reset = 1'b1;
        idle_all();
        step();
        step();
        check("reset ready", 128'(ready), '0);
        check("reset rd_data", 128'(rd_data), '0);
`ifdef ARB_STALL_CNT_EN
        check("reset stall_cnt", 128'(stall_cnt), '0);
`endif
        reset = 1'b0;

        // single-core vectors
        for (int i = 0; i < 9; i++) begin
            idle_all();
            set_req(tbl[i].core, tbl[i].en, tbl[i].ad, tbl[i].wd);
            step();
            check($sformatf("tbl%0d ready", i), 128'(ready), bitm(tbl[i].core));
            check($sformatf("tbl%0d rd_data", i), 128'(rd_data), lane(tbl[i].core, tbl[i].exp_rd));
            idle_all();
            step();
            check($sformatf("tbl%0d idle", i), 128'(ready), '0);
        end

        // parallel writes to three banks, then parallel readback
        idle_all();
        set_req(1, 2'b10, 8'h00, 8'h11);
        set_req(2, 2'b10, 8'h40, 8'h22);
        set_req(3, 2'b10, 8'h80, 8'h33);
        step();
        check("par wr ready", 128'(ready), 128'h000E);
        check("par wr rd_data", 128'(rd_data), '0);
        idle_all();
        step();
        set_req(1, 2'b01, 8'h00, 8'h00);
        set_req(2, 2'b01, 8'h40, 8'h00);
        set_req(3, 2'b01, 8'h80, 8'h00);
        step();
        check("par rd ready", 128'(ready), 128'h000E);
        check("par rd rd_data", 128'(rd_data), lane(1, 8'h11) | lane(2, 8'h22) | lane(3, 8'h33));
        idle_all();
        step();

        // bank-0 collision from reset, each core drops after its ready
        pulse_reset();
        set_req(0, 2'b01, 8'h00, 8'h00);
        set_req(5, 2'b01, 8'h03, 8'h00);
        set_req(9, 2'b01, 8'h00, 8'h00);
        step();
        check("rr c0", 128'(ready), bitm(0));
        check("rr c0 data", 128'(rd_data), lane(0, 8'h11));
        set_req(0, 2'b00, 8'h00, 8'h00);
        step();
        check("rr c5", 128'(ready), bitm(5));
        check("rr c5 data", 128'(rd_data), lane(5, 8'h5A));
        set_req(5, 2'b00, 8'h00, 8'h00);
        step();
        check("rr c9", 128'(ready), bitm(9));
        check("rr c9 data", 128'(rd_data), lane(9, 8'h11));
        set_req(9, 2'b00, 8'h00, 8'h00);
        step();
        check("rr done", 128'(ready), '0);
`ifdef ARB_STALL_CNT_EN
        check("rr stall_cnt", 128'(stall_cnt), 128'd2);
`endif

        // same collision, core 0 keeps requesting and must wait behind core 9
        pulse_reset();
        set_req(0, 2'b01, 8'h00, 8'h00);
        set_req(5, 2'b01, 8'h03, 8'h00);
        set_req(9, 2'b01, 8'h00, 8'h00);
        step();
        check("rr2 c0", 128'(ready), bitm(0));
        step();
        check("rr2 c5", 128'(ready), bitm(5));
        set_req(5, 2'b00, 8'h00, 8'h00);
        step();
        check("rr2 c9", 128'(ready), bitm(9));
        set_req(9, 2'b00, 8'h00, 8'h00);
        step();
        check("rr2 c0 again", 128'(ready), bitm(0));
        check("rr2 c0 data", 128'(rd_data), lane(0, 8'h11));
        idle_all();
        step();

        // held read completes every other cycle
        set_req(4, 2'b01, 8'h40, 8'h00);
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("hold%0d ready", i), 128'(ready), (i % 2 == 0) ? bitm(4) : '0);
            check($sformatf("hold%0d rd_data", i), 128'(rd_data),
                  (i % 2 == 0) ? lane(4, 8'h22) : '0);
        end
        idle_all();
        step();
        step();

        // reset during a grant cycle: pulses dropped, read lost, pointers back to 15
        set_req(3, 2'b01, 8'h03, 8'h00);
        step();
        check("pre-reset ready", 128'(ready), bitm(3));
        idle_all();
        set_req(1, 2'b01, 8'h03, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        check("async drop ready", 128'(ready), '0);
        check("async drop rd_data", 128'(rd_data), '0);
        @(posedge clk);
        #1;
        check("reset grant ready", 128'(ready), '0);
        check("reset grant rd_data", 128'(rd_data), '0);
        reset = 1'b0;
        idle_all();
        set_req(0, 2'b01, 8'h03, 8'h00);
        set_req(15, 2'b01, 8'h03, 8'h00);
        step();
        check("ptr after reset", 128'(ready), bitm(0));
        idle_all();
        step();

        // randomized traffic against the reference model
        pulse_reset();
        for (int c = 0; c < NC; c++) begin
            pend[c]  = 1'b0;
            m_inf[c] = 1'b0;
            r_en[c]  = 2'b00;
            r_ad[c]  = 8'h00;
            r_wd[c]  = 8'h00;
        end
        for (int b = 0; b < NB; b++) m_ptr[b] = NC - 1;
        for (int a = 0; a < 256; a++) m_known[a] = 1'b0;
        m_stall    = 0;
        exp_ready  = '0;
        exp_rd     = '0;
        known_mask = '1;
        for (int t = 0; t < 3000; t++) begin
            check("rand ready", 128'(ready), 128'(exp_ready));
            check("rand rd_data", 128'(rd_data) & known_mask, exp_rd & known_mask);
`ifdef ARB_STALL_CNT_EN
            check("rand stall_cnt", 128'(stall_cnt), 128'(m_stall));
`endif
            for (int c = 0; c < NC; c++) begin
                if (exp_ready[c]) pend[c] = 1'b0;
                if (!pend[c] && $urandom_range(0, 9) < 6) begin
                    pend[c] = 1'b1;
                    r_en[c] = 2'($urandom_range(1, 3));
                    r_ad[c] = 8'($urandom_range(0, 3) * 64 + $urandom_range(0, 3));
                    r_wd[c] = 8'($urandom);
                end
                if (!pend[c]) r_en[c] = 2'b00;
                set_req(c, r_en[c], r_ad[c], r_wd[c]);
            end
            model_step();
            step();
        end
        idle_all();
        step();

`ifdef ARB_STALL_CNT_EN
        // three cores fighting for one bank stall every cycle; counter must saturate
        pulse_reset();
        set_req(0, 2'b01, 8'h00, 8'h00);
        set_req(1, 2'b01, 8'h00, 8'h00);
        set_req(2, 2'b01, 8'h00, 8'h00);
        for (int i = 0; i < 70000; i++) @(posedge clk);
        #1;
        check("stall saturate", 128'(stall_cnt), 128'hFFFF);
        idle_all();
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
